alu_seq_muldiv: RTL

// - Parametrised, registered ALU with valid/ready handshakes on input and output.
//   It sits between operand fetch and writeback in the pipelined datapath.
// - Single-cycle ops: logic, add/sub, shifts, compares; result is registered (latency 1).
// - Adds unsigned MUL/MULHU/DIVU/REMU using an iterative shift-add/restoring datapath.
// - Backpressure stalls the unit; a held result is never overwritten.

---
 rtl/alu_seq_muldiv_pkg.sv | 43 ++++
 rtl/alu_seq_muldiv_if.sv | 29 ++
 rtl/alu_seq_muldiv_iter.sv | 77 +++++++
 rtl/alu_seq_muldiv.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_seq_muldiv_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states and
// the decode that separates single-cycle opcodes from the iterative mul/div group.
package alu_seq_muldiv_pkg;

   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_SUB   = 5'h01;
   localparam logic [4:0] OP_SLL   = 5'h02;
   localparam logic [4:0] OP_SRL   = 5'h03;
   localparam logic [4:0] OP_SLLV  = 5'h04;
   localparam logic [4:0] OP_SRLV  = 5'h05;
   localparam logic [4:0] OP_SRAV  = 5'h06;
   localparam logic [4:0] OP_AND   = 5'h07;
   localparam logic [4:0] OP_NAND  = 5'h08;
   localparam logic [4:0] OP_OR    = 5'h09;
   localparam logic [4:0] OP_NOR   = 5'h0A;
   localparam logic [4:0] OP_XOR   = 5'h0B;
   localparam logic [4:0] OP_XNOR  = 5'h0C;
   localparam logic [4:0] OP_SRA   = 5'h0D;
   localparam logic [4:0] OP_SLTU  = 5'h0E;
   localparam logic [4:0] OP_SLT   = 5'h0F;
   localparam logic [4:0] OP_MUL   = 5'h10;
   localparam logic [4:0] OP_MULHU = 5'h11;
   localparam logic [4:0] OP_DIVU  = 5'h12;
   localparam logic [4:0] OP_REMU  = 5'h13;

   typedef enum logic {
      S_IDLE,
      S_ITER
   } state_e;

   // Low two opcode bits of the iterative group: bit 1 selects divide, bit 0 the upper word.
   typedef enum logic [1:0] {
      IT_MUL   = 2'b00,
      IT_MULHU = 2'b01,
      IT_DIVU  = 2'b10,
      IT_REMU  = 2'b11
   } iter_op_e;

   function automatic logic is_iter(input logic [4:0] op);
      return op[4:2] == 3'b100;
   endfunction

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Operand/result handshake bundle between operand fetch (master) and the ALU (slave).
interface alu_seq_muldiv_if #(
   parameter int DWL  = 32,
   parameter int SHW  = $clog2(DWL),
   parameter int SELW = 5
);
   logic            InValid;
   logic            InReady;
   logic [SELW-1:0] ALUSel;
   logic [DWL-1:0]  ALUIn1;
   logic [DWL-1:0]  ALUIn2;
   logic [SHW-1:0]  Shamt;
   logic            OutValid;
   logic            OutReady;
   logic [DWL-1:0]  ALUOut;
   logic            Zero;
   logic            Illegal;
   logic            DivZero;

   modport master (
      output InValid, ALUSel, ALUIn1, ALUIn2, Shamt, OutReady,
      input  InReady, OutValid, ALUOut, Zero, Illegal, DivZero
   );

   modport slave (
      input  InValid, ALUSel, ALUIn1, ALUIn2, Shamt, OutReady,
      output InReady, OutValid, ALUOut, Zero, Illegal, DivZero
   );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and divider (restoring), one bit per cycle.
// done_o marks the final step; result_o is that step's outcome, valid only with done_o.
module alu_muldiv_iter
   import alu_seq_muldiv_pkg::*;
#(
   parameter int DWL = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  iter_op_e       op_i,
   input  logic [DWL-1:0] a_i,
   input  logic [DWL-1:0] b_i,
   output logic           done_o,
   output logic [DWL-1:0] result_o,
   output logic           div0_o
);
   localparam int CW = $clog2(DWL + 1);

   logic [CW-1:0]  cnt_q;
   iter_op_e       op_q;
   logic [DWL-1:0] opd_q;
   logic [DWL-1:0] hi_q, lo_q;
   logic           div0_q;
   logic [DWL-1:0] hi_d, lo_d;
   logic [DWL:0]   sum, r_sh;
   logic [DWL-1:0] diff;
   logic           ge;
   logic           busy;

   assign busy = (cnt_q != '0);

   // hi:lo is the running product for multiply and remainder:quotient for divide.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      r_sh = {hi_q, lo_q[DWL-1]};
      ge   = (r_sh >= {1'b0, opd_q});
      diff = r_sh[DWL-1:0] - opd_q;
      hi_d = sum[DWL:1];
      lo_d = {sum[0], lo_q[DWL-1:1]};
      if (op_q[1]) begin
         hi_d = ge ? diff : r_sh[DWL-1:0];
         lo_d = {lo_q[DWL-2:0], ge};
      end
   end

   assign done_o   = (cnt_q == CW'(1));
   assign result_o = op_q[0] ? hi_d : lo_d;
   assign div0_o   = div0_q;

   always_ff @(posedge clk_i) begin
      // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
      if (rst_i) begin
         cnt_q <= '0;
      end else if (start_i) begin
         cnt_q <= CW'(DWL);
      end else if (busy) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // NOTE: datapath registers carry no reset; they are only observed while the counter runs.
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         op_q   <= op_i;
         opd_q  <= op_i[1] ? b_i : a_i;
         lo_q   <= op_i[1] ? a_i : b_i;
         hi_q   <= '0;
         div0_q <= op_i[1] && (b_i == '0);
      end else if (busy) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered ALU with valid/ready handshakes: single-cycle ops complete in one cycle,
// unsigned mul/div run DWL steps in alu_muldiv_iter while the input side is stalled.
module alu_seq_muldiv
   import alu_seq_muldiv_pkg::*;
#(
   parameter int DWL  = 32,
   parameter int SHW  = $clog2(DWL),
   parameter int SELW = 5
) (
   input  logic             CLK,
   input  logic             RST,
   alu_seq_muldiv_if.slave  bus
);
   state_e         state_q;
   logic           out_valid_q, zero_q, ill_q, div0_q;
   logic [DWL-1:0] alu_out_q;

   logic [4:0]     op;
   logic           sel_hi_nz;
   logic [SHW-1:0] vsh;
   logic [DWL-1:0] a, b;
   logic [DWL-1:0] alu_res;
   logic           alu_ill;
   logic           in_ready, in_fire, out_fire, iter_op, load_one;
   logic           it_done, it_div0;
   logic [DWL-1:0] it_result;
   logic           load_d, ill_d, div0_d;
   logic [DWL-1:0] res_d;

   assign op        = bus.ALUSel[4:0];
   assign sel_hi_nz = |(bus.ALUSel >> 5);
   assign a         = bus.ALUIn1;
   assign b         = bus.ALUIn2;
   assign vsh       = a[SHW-1:0];

   // Shifts act on operand B; variable shifts take the amount from the low bits of A.
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (op)
         OP_ADD:   alu_res = a + b;
         OP_SUB:   alu_res = a - b;
         OP_SLL:   alu_res = b << bus.Shamt;
         OP_SRL:   alu_res = b >> bus.Shamt;
         OP_SLLV:  alu_res = b << vsh;
         OP_SRLV:  alu_res = b >> vsh;
         OP_SRAV:  alu_res = $unsigned($signed(b) >>> vsh);
         OP_AND:   alu_res = a & b;
         OP_NAND:  alu_res = ~(a & b);
         OP_OR:    alu_res = a | b;
         OP_NOR:   alu_res = ~(a | b);
         OP_XOR:   alu_res = a ^ b;
         OP_XNOR:  alu_res = ~(a ^ b);
         OP_SRA:   alu_res = $unsigned($signed(b) >>> bus.Shamt);
         OP_SLTU:  alu_res = DWL'(a < b);
         OP_SLT:   alu_res = DWL'($signed(a) < $signed(b));
         OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
         default:  alu_ill = 1'b1;
      endcase
      if (sel_hi_nz) begin
         alu_res = '0;
         alu_ill = 1'b1;
      end
   end

   assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.OutReady);
   assign in_fire  = bus.InValid && in_ready;
   assign out_fire = out_valid_q && bus.OutReady;
   assign iter_op  = is_iter(op) && !sel_hi_nz;
   assign load_one = in_fire && !iter_op;

   alu_muldiv_iter #(.DWL(DWL)) u_iter (
      .clk_i    (CLK),
      .rst_i    (RST),
      .start_i  (in_fire && iter_op),
      .op_i     (iter_op_e'(op[1:0])),
      .a_i      (a),
      .b_i      (b),
      .done_o   (it_done),
      .result_o (it_result),
      .div0_o   (it_div0)
   );

   assign load_d = load_one || it_done;
   assign res_d  = it_done ? it_result : alu_res;
   assign ill_d  = it_done ? 1'b0 : alu_ill;
   assign div0_d = it_done ? it_div0 : 1'b0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         zero_q      <= 1'b0;
         ill_q       <= 1'b0;
         div0_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:  if (in_fire && iter_op) state_q <= S_ITER;
            S_ITER:  if (it_done) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         // A new result wins over the clear, giving one result per cycle when streaming.
         if (load_d) begin
            out_valid_q <= 1'b1;
            alu_out_q   <= res_d;
            zero_q      <= (res_d == '0);
            ill_q       <= ill_d;
            div0_q      <= div0_d;
         end else if (out_fire) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.InReady  = in_ready;
   assign bus.OutValid = out_valid_q;
   assign bus.ALUOut   = alu_out_q;
   assign bus.Zero     = zero_q;
   assign bus.Illegal  = ill_q;
   assign bus.DivZero  = div0_q;

endmodule
